bp_axi_mem_responder: RTL and testbench
=======================================

BP_AXI_MEM_RESPONDER -- requirements
Module: bp_axi_mem_responder

Interface
REQ-001 SHALL have parameter axi_id_width_p, default 1, AXI ID width.
REQ-002 SHALL have parameter axi_addr_width_p, default 30, AXI byte-address width.
REQ-003 SHALL have parameter axi_data_width_p, default 256, AXI data width (power of 2, >=64).
REQ-004 SHALL have parameter mem_addr_width_p, default 20, memory word-address width.
REQ-005 SHALL have ports clk_i (in, 1, sole clock) and reset_n_i (in, 1, synchronous active-low reset).
REQ-006 SHALL have AW slave ports axi_awid_i, axi_awaddr_i, axi_awlen_i[7:0], axi_awsize_i[2:0], axi_awburst_i[1:0], axi_awvalid_i (in) and axi_awready_o (out).
REQ-007 SHALL have W ports axi_wdata_i, axi_wstrb_i[data/8], axi_wlast_i, axi_wvalid_i (in) and axi_wready_o (out).
REQ-008 SHALL have B ports axi_bid_o, axi_bresp_o[1:0], axi_bvalid_o (out) and axi_bready_i (in).
REQ-009 SHALL have AR ports axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i, axi_arvalid_i (in) and axi_arready_o (out).
REQ-010 SHALL have R ports axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o (out) and axi_rready_i (in).
REQ-011 SHALL have memory ports mem_v_o, mem_w_o, mem_addr_o[mem_addr_width_p], mem_data_o[data], mem_mask_o[data/8] (out) and mem_data_i[data] (in, valid exactly one cycle after a read with mem_v_o=1).

Function
REQ-012 SHALL use FSM states IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_WAIT, RD_RESP.
REQ-013 IDLE: axi_awready_o/axi_arready_o SHALL assert combinationally in IDLE only; one address accepted per handshake.
REQ-014 Both AW and AR valid in IDLE: SHALL grant the channel not served last (round-robin bit, reset to favour write).
REQ-015 On accept SHALL latch id, beat count len+1 (1..256), word address = addr >> log2(data/8) truncated to mem_addr_width_p, and legal flag = (burst==INCR 2'b01 && size==log2(data/8)).
REQ-016 WR_DATA: axi_wready_o=1; each W handshake SHALL drive mem_v_o=1, mem_w_o=1, mem_mask_o=wstrb (0 if illegal), same cycle, then word address +1 mod 2^mem_addr_width_p.
REQ-017 Last write beat = wlast or count exhausted; wlast mismatch with count SHALL set SLVERR; then go to WR_RESP.
REQ-018 WR_RESP: axi_bvalid_o=1, bid=latched id, bresp=OKAY(00) or SLVERR(10); held stable until bready, then IDLE.
REQ-019 RD_ISSUE: SHALL drive mem_v_o=1, mem_w_o=0 (suppressed if illegal) for one cycle, then RD_WAIT.
REQ-020 RD_WAIT: SHALL capture mem_data_i (zero if illegal) into an R register, then RD_RESP.
REQ-021 RD_RESP: axi_rvalid_o=1, rdata/rid/rresp/rlast stable until rready; rlast=1 on beat len+1; on handshake address+1, then RD_ISSUE or IDLE after last.
REQ-022 Read throughput SHALL be one beat per 3 cycles minimum; write throughput one beat per cycle.
REQ-023 No outstanding transactions beyond one; AXI IDs SHALL only be echoed, never reordered.
REQ-024 mem_v_o SHALL be 0 in all other states; mem_data_o=wdata combinationally.

Reset
REQ-025 reset_n_i low on a clock edge SHALL force IDLE, round-robin bit to write, all valid/ready outputs and mem_v_o to 0, latched id/resp/count to 0.
REQ-026 Reset mid-burst SHALL abandon the burst with no B/R response and no further memory access.

Structure
REQ-027 AXI burst/resp encodings (INCR, OKAY, SLVERR) and FSM state enum SHALL live in bp_me_pkg.
REQ-028 R output register SHALL be bsg_dff_en_bypass-free plain register; no sub-module other than optional bsg_counter_clear_up for beat count.

Verification
REQ-029 Write: AW addr 0x40, len 1, INCR, size 5; two W beats strb all-ones -> mem writes at word 2,3; B OKAY with matching id.
REQ-030 Read: AR addr 0x40, len 1 after REQ-029 -> two R beats with written data, rlast on beat 2, rresp OKAY.
REQ-031 Simultaneous AW and AR in IDLE twice -> first grant write, second read.
REQ-032 AR burst FIXED (00) len 3 -> 4 beats rdata 0, rresp SLVERR, no mem_v_o.
REQ-033 rready held low 10 cycles mid-burst -> R outputs stable, no extra mem reads.
REQ-034 reset_n_i low during WR_DATA beat 2 of 4 -> all outputs 0 next cycle, no bvalid; subsequent write completes normally.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared AXI encodings and the responder FSM state type.
package bp_me_pkg;

   localparam logic [1:0] AxiBurstIncr  = 2'b01;
   localparam logic [1:0] AxiRespOkay   = 2'b00;
   localparam logic [1:0] AxiRespSlverr = 2'b10;

   typedef enum logic [2:0] {
      StIdle,
      StWrData,
      StWrResp,
      StRdIssue,
      StRdWait,
      StRdResp
   } state_e;

endpackage

// File: rtl/bp_axi_mem_responder.sv
// Single-outstanding AXI4 slave that turns INCR bursts into word accesses on a
// simple synchronous memory port (read data returns one cycle after the request).
module bp_axi_mem_responder
   import bp_me_pkg::*;
#(
   parameter int unsigned axi_id_width_p   = 1,
   parameter int unsigned axi_addr_width_p = 30,
   parameter int unsigned axi_data_width_p = 256,
   parameter int unsigned mem_addr_width_p = 20
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,

   input  logic [axi_id_width_p-1:0]     axi_awid_i,
   input  logic [axi_addr_width_p-1:0]   axi_awaddr_i,
   input  logic [7:0]                    axi_awlen_i,
   input  logic [2:0]                    axi_awsize_i,
   input  logic [1:0]                    axi_awburst_i,
   input  logic                          axi_awvalid_i,
   output logic                          axi_awready_o,

   input  logic [axi_data_width_p-1:0]   axi_wdata_i,
   input  logic [axi_data_width_p/8-1:0] axi_wstrb_i,
   input  logic                          axi_wlast_i,
   input  logic                          axi_wvalid_i,
   output logic                          axi_wready_o,

   output logic [axi_id_width_p-1:0]     axi_bid_o,
   output logic [1:0]                    axi_bresp_o,
   output logic                          axi_bvalid_o,
   input  logic                          axi_bready_i,

   input  logic [axi_id_width_p-1:0]     axi_arid_i,
   input  logic [axi_addr_width_p-1:0]   axi_araddr_i,
   input  logic [7:0]                    axi_arlen_i,
   input  logic [2:0]                    axi_arsize_i,
   input  logic [1:0]                    axi_arburst_i,
   input  logic                          axi_arvalid_i,
   output logic                          axi_arready_o,

   output logic [axi_id_width_p-1:0]     axi_rid_o,
   output logic [axi_data_width_p-1:0]   axi_rdata_o,
   output logic [1:0]                    axi_rresp_o,
   output logic                          axi_rlast_o,
   output logic                          axi_rvalid_o,
   input  logic                          axi_rready_i,

   output logic                          mem_v_o,
   output logic                          mem_w_o,
   output logic [mem_addr_width_p-1:0]   mem_addr_o,
   output logic [axi_data_width_p-1:0]   mem_data_o,
   output logic [axi_data_width_p/8-1:0] mem_mask_o,
   input  logic [axi_data_width_p-1:0]   mem_data_i
);

   localparam int unsigned offset_lp = $clog2(axi_data_width_p / 8);
   localparam logic [2:0]  size_lp   = 3'(offset_lp);

   state_e                        state_q, state_d;
   logic                          prefer_read_q;
   logic [axi_id_width_p-1:0]     id_q;
   logic [8:0]                    count_q;
   logic [mem_addr_width_p-1:0]   addr_q;
   logic                          legal_q;
   logic [1:0]                    resp_q;
   logic [axi_data_width_p-1:0]   rdata_q;

   logic aw_hs, ar_hs, w_hs, r_hs, last_beat, aw_legal, ar_legal;

   assign aw_hs     = axi_awvalid_i & axi_awready_o;
   assign ar_hs     = axi_arvalid_i & axi_arready_o;
   assign w_hs      = axi_wvalid_i & axi_wready_o;
   assign r_hs      = axi_rvalid_o & axi_rready_i;
   assign last_beat = (count_q == 9'd1);
   assign aw_legal  = (axi_awburst_i == AxiBurstIncr) && (axi_awsize_i == size_lp);
   assign ar_legal  = (axi_arburst_i == AxiBurstIncr) && (axi_arsize_i == size_lp);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) state_q <= StIdle;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (aw_hs)      state_d = StWrData;
            else if (ar_hs) state_d = StRdIssue;
         end
         StWrData:  if (w_hs && (axi_wlast_i || last_beat)) state_d = StWrResp;
         StWrResp:  if (axi_bready_i) state_d = StIdle;
         StRdIssue: state_d = StRdWait;
         StRdWait:  state_d = StRdResp;
         StRdResp:  if (r_hs) state_d = last_beat ? StIdle : StRdIssue;
         default:   state_d = StIdle;
      endcase
   end

   // Handshake outputs are masked while reset is held so nothing is accepted or issued.
   always_comb begin
      axi_awready_o = 1'b0;
      axi_arready_o = 1'b0;
      axi_wready_o  = 1'b0;
      axi_bvalid_o  = 1'b0;
      axi_rvalid_o  = 1'b0;
      mem_v_o       = 1'b0;
      mem_w_o       = 1'b0;
      mem_addr_o    = addr_q;
      mem_data_o    = axi_wdata_i;
      mem_mask_o    = legal_q ? axi_wstrb_i : '0;
      axi_bid_o     = id_q;
      axi_bresp_o   = resp_q;
      axi_rid_o     = id_q;
      axi_rdata_o   = rdata_q;
      axi_rresp_o   = resp_q;
      axi_rlast_o   = last_beat;
      if (reset_n_i) begin
         unique case (state_q)
            StIdle: begin
               axi_awready_o = !(axi_arvalid_i && prefer_read_q);
               axi_arready_o = !(axi_awvalid_i && !prefer_read_q);
            end
            StWrData: begin
               axi_wready_o = 1'b1;
               mem_v_o      = axi_wvalid_i;
               mem_w_o      = 1'b1;
            end
            StWrResp:  axi_bvalid_o = 1'b1;
            StRdIssue: mem_v_o      = legal_q;
            StRdResp:  axi_rvalid_o = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         prefer_read_q <= 1'b0;
         id_q          <= '0;
         count_q       <= '0;
         addr_q        <= '0;
         legal_q       <= 1'b0;
         resp_q        <= AxiRespOkay;
         rdata_q       <= '0;
      end else begin
         if (aw_hs) begin
            id_q          <= axi_awid_i;
            count_q       <= {1'b0, axi_awlen_i} + 9'd1;
            addr_q        <= mem_addr_width_p'(axi_awaddr_i >> offset_lp);
            legal_q       <= aw_legal;
            resp_q        <= aw_legal ? AxiRespOkay : AxiRespSlverr;
            prefer_read_q <= 1'b1;
         end else if (ar_hs) begin
            id_q          <= axi_arid_i;
            count_q       <= {1'b0, axi_arlen_i} + 9'd1;
            addr_q        <= mem_addr_width_p'(axi_araddr_i >> offset_lp);
            legal_q       <= ar_legal;
            resp_q        <= ar_legal ? AxiRespOkay : AxiRespSlverr;
            prefer_read_q <= 1'b0;
         end
         if (w_hs || r_hs) begin
            addr_q  <= addr_q + mem_addr_width_p'(1);
            count_q <= count_q - 9'd1;
         end
         // wlast arriving early or late relative to awlen marks the burst bad.
         if (w_hs && (axi_wlast_i != last_beat)) resp_q <= AxiRespSlverr;
         if (state_q == StRdWait) rdata_q <= legal_q ? mem_data_i : '0;
      end
   end

endmodule

// File: tb/tb_bp_axi_mem_responder.sv
// Directed bench: table of AXI bursts against a small behavioural memory, plus
// arbitration, R back-pressure and mid-burst reset sequences.
module tb_bp_axi_mem_responder;
   import bp_me_pkg::*;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [0:0]   awid, arid, bid, rid;
   logic [29:0]  awaddr, araddr;
   logic [7:0]   awlen, arlen;
   logic [2:0]   awsize, arsize;
   logic [1:0]   awburst, arburst, bresp, rresp;
   logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic         arvalid, arready, rlast, rvalid, rready;
   logic [255:0] wdata, rdata, mem_data_o, mem_data_i;
   logic [31:0]  wstrb, mem_mask;
   logic         mem_v, mem_w;
   logic [19:0]  mem_addr;

   int total = 0;
   int passed = 0;
   int wr_cnt = 0;
   int rd_cnt = 0;
   logic [255:0] mem [128];

   always #5 clk = ~clk;

   bp_axi_mem_responder #(
      .axi_id_width_p(1), .axi_addr_width_p(30), .axi_data_width_p(256), .mem_addr_width_p(20)
   ) dut (
      .clk_i(clk), .reset_n_i(reset_n),
      .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(awsize),
      .axi_awburst_i(awburst), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
      .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast), .axi_wvalid_i(wvalid),
      .axi_wready_o(wready),
      .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
      .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(arsize),
      .axi_arburst_i(arburst), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
      .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
      .axi_rvalid_o(rvalid), .axi_rready_i(rready),
      .mem_v_o(mem_v), .mem_w_o(mem_w), .mem_addr_o(mem_addr), .mem_data_o(mem_data_o),
      .mem_mask_o(mem_mask), .mem_data_i(mem_data_i)
   );

   // Behavioural memory: byte-masked writes, read data one cycle after the request.
   always @(posedge clk) begin
      if (mem_v && mem_w) begin
         for (int i = 0; i < 32; i++)
            if (mem_mask[i]) mem[mem_addr[6:0]][i*8 +: 8] <= mem_data_o[i*8 +: 8];
         wr_cnt <= wr_cnt + 1;
      end else if (mem_v) begin
         mem_data_i <= mem[mem_addr[6:0]];
         rd_cnt     <= rd_cnt + 1;
      end
   end

   function automatic logic [255:0] beat_data(input logic [31:0] seed, input int unsigned b);
      logic [31:0] w;
      w = seed + b;
      return {8{w}};
   endfunction

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual %h required %h", name, act, exp);
   endtask

   task automatic timeout(input string name);
      total++;
      $display("FAIL %s: timeout waiting for handshake", name);
   endtask

   task automatic send_aw(input logic [0:0] id, input logic [29:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
      bit ok = 0;
      awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = awready;
      end
      if (!ok) timeout("aw_ready");
      @(posedge clk); #1 awvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [0:0] id, input logic [29:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size);
      bit ok = 0;
      arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = arready;
      end
      if (!ok) timeout("ar_ready");
      @(posedge clk); #1 arvalid = 1'b0;
   endtask

   task automatic send_w(input int word, input int beats, input int wlast_beat, input bit legal,
                         input logic [31:0] seed);
      for (int b = 0; b < beats; b++) begin
         bit ok = 0;
         wvalid = 1'b1; wdata = beat_data(seed, b); wstrb = '1; wlast = (b == wlast_beat);
         for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = wready;
         end
         if (!ok) timeout("w_ready");
         check("w_mem_v", 256'(mem_v), 256'(1));
         check("w_mem_w", 256'(mem_w), 256'(1));
         check("w_mem_addr", 256'(mem_addr), 256'(word + b));
         check("w_mem_mask", 256'(mem_mask), legal ? 256'(32'hFFFF_FFFF) : 256'(0));
         @(posedge clk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic recv_b(input logic [0:0] id, input logic [1:0] resp);
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = bvalid;
      end
      if (!ok) timeout("b_valid");
      check("b_id", 256'(bid), 256'(id));
      check("b_resp", 256'(bresp), 256'(resp));
      bready = 1'b1;
      @(posedge clk); #1 bready = 1'b0;
   endtask

   task automatic recv_r(input logic [0:0] id, input int len, input logic [1:0] resp,
                         input logic [31:0] seed, input int stall_beat);
      for (int b = 0; b <= len; b++) begin
         bit ok = 0;
         logic [255:0] exp;
         exp = (resp == AxiRespOkay) ? beat_data(seed, b) : '0;
         for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = rvalid;
         end
         if (!ok) timeout("r_valid");
         check("r_id", 256'(rid), 256'(id));
         check("r_resp", 256'(rresp), 256'(resp));
         check("r_last", 256'(rlast), 256'(b == len));
         check("r_data", rdata, exp);
         if (b == stall_beat) begin
            int rc = rd_cnt;
            repeat (10) begin
               @(negedge clk);
               check("stall_r_valid", 256'(rvalid), 256'(1));
               check("stall_r_data", rdata, exp);
               check("stall_r_last", 256'(rlast), 256'(b == len));
            end
            check("stall_no_mem_read", 256'(rd_cnt), 256'(rc));
         end
         rready = 1'b1;
         @(posedge clk); #1 rready = 1'b0;
      end
   endtask

   typedef struct {
      bit          is_wr;
      logic [0:0]  id;
      logic [29:0] addr;
      logic [7:0]  len;
      logic [1:0]  burst;
      logic [2:0]  size;
      logic [31:0] seed;
      int          wlast_beat;
      bit          legal;
      logic [1:0]  resp;
      int          word;
      int          beats;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int w0, r0;
      vecs[0] = '{1'b1, 1'b1, 30'h40,  8'd1, AxiBurstIncr, 3'd5, 32'hA000_0000, 1, 1'b1, AxiRespOkay,   2,  2};
      vecs[1] = '{1'b0, 1'b1, 30'h40,  8'd1, AxiBurstIncr, 3'd5, 32'hA000_0000, 0, 1'b1, AxiRespOkay,   2,  2};
      vecs[2] = '{1'b1, 1'b0, 30'h100, 8'd3, AxiBurstIncr, 3'd5, 32'hB000_0000, 3, 1'b1, AxiRespOkay,   8,  4};
      vecs[3] = '{1'b0, 1'b0, 30'h100, 8'd3, AxiBurstIncr, 3'd5, 32'hB000_0000, 0, 1'b1, AxiRespOkay,   8,  4};
      vecs[4] = '{1'b0, 1'b1, 30'h100, 8'd3, 2'b00,        3'd5, 32'h0,         0, 1'b0, AxiRespSlverr, 8,  4};
      vecs[5] = '{1'b1, 1'b0, 30'h40,  8'd0, AxiBurstIncr, 3'd4, 32'h7700_0000, 0, 1'b0, AxiRespSlverr, 2,  1};
      vecs[6] = '{1'b1, 1'b1, 30'h200, 8'd1, AxiBurstIncr, 3'd5, 32'hC000_0000, 0, 1'b1, AxiRespSlverr, 16, 1};
      vecs[7] = '{1'b0, 1'b0, 30'h40,  8'd0, AxiBurstIncr, 3'd5, 32'hA000_0000, 0, 1'b1, AxiRespOkay,   2,  1};

      reset_n = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0; rready = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 256'({awready, arready, wready, bvalid, rvalid, mem_v}), 256'(6'b0));
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      check("idle_outputs", 256'({awready, arready, wready, bvalid, rvalid, mem_v}), 256'(6'b110000));
      @(posedge clk); #1;

      for (int v = 0; v < 8; v++) begin
         if (vecs[v].is_wr) begin
            w0 = wr_cnt;
            send_aw(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst, vecs[v].size);
            send_w(vecs[v].word, vecs[v].beats, vecs[v].wlast_beat, vecs[v].legal, vecs[v].seed);
            recv_b(vecs[v].id, vecs[v].resp);
            check("wr_mem_count", 256'(wr_cnt - w0), 256'(vecs[v].beats));
         end else begin
            r0 = rd_cnt;
            send_ar(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst, vecs[v].size);
            recv_r(vecs[v].id, int'(vecs[v].len), vecs[v].resp, vecs[v].seed, -1);
            check("rd_mem_count", 256'(rd_cnt - r0), vecs[v].legal ? 256'(vecs[v].beats) : 256'(0));
         end
      end

      // Simultaneous AW/AR twice: write wins first, then read.
      awid = 1'b1; awaddr = 30'h400; awlen = 8'd0; awburst = AxiBurstIncr; awsize = 3'd5;
      arid = 1'b0; araddr = 30'h40;  arlen = 8'd0; arburst = AxiBurstIncr; arsize = 3'd5;
      awvalid = 1'b1; arvalid = 1'b1;
      @(negedge clk);
      check("arb1_ready", 256'({awready, arready}), 256'(2'b10));
      @(posedge clk); #1 awvalid = 1'b0; arvalid = 1'b0;
      send_w(32, 1, 0, 1'b1, 32'hE000_0000);
      recv_b(1'b1, AxiRespOkay);
      awvalid = 1'b1; arvalid = 1'b1;
      @(negedge clk);
      check("arb2_ready", 256'({awready, arready}), 256'(2'b01));
      @(posedge clk); #1 awvalid = 1'b0; arvalid = 1'b0;
      recv_r(1'b0, 0, AxiRespOkay, 32'hA000_0000, -1);

      // rready held low mid-burst.
      r0 = rd_cnt;
      send_ar(1'b1, 30'h100, 8'd3, AxiBurstIncr, 3'd5);
      recv_r(1'b1, 3, AxiRespOkay, 32'hB000_0000, 1);
      check("stall_rd_count", 256'(rd_cnt - r0), 256'(4));

      // Reset during the second of four write beats.
      w0 = wr_cnt;
      send_aw(1'b0, 30'h800, 8'd3, AxiBurstIncr, 3'd5);
      send_w(64, 1, 3, 1'b1, 32'hF000_0000);
      wvalid = 1'b1; wdata = beat_data(32'hF000_0000, 1); wlast = 1'b0; reset_n = 1'b0;
      @(negedge clk);
      check("midrst_outputs", 256'({awready, arready, wready, bvalid, rvalid, mem_v}), 256'(6'b0));
      @(posedge clk); #1 reset_n = 1'b1; wvalid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_quiet", 256'({wready, bvalid, rvalid, mem_v}), 256'(4'b0));
      end
      check("midrst_wr_count", 256'(wr_cnt - w0), 256'(1));
      @(posedge clk); #1;

      awid = 1'b1; awaddr = 30'h40;  awlen = 8'd1; awburst = AxiBurstIncr; awsize = 3'd5;
      arid = 1'b0; araddr = 30'h100; arlen = 8'd0; arburst = AxiBurstIncr; arsize = 3'd5;
      awvalid = 1'b1; arvalid = 1'b1;
      @(negedge clk);
      check("rr_after_reset", 256'({awready, arready}), 256'(2'b10));
      @(posedge clk); #1 awvalid = 1'b0; arvalid = 1'b0;
      send_w(2, 2, 1, 1'b1, 32'hD000_0000);
      recv_b(1'b1, AxiRespOkay);
      send_ar(1'b0, 30'h40, 8'd1, AxiBurstIncr, 3'd5);
      recv_r(1'b0, 1, AxiRespOkay, 32'hD000_0000, -1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
